connect4_move_input: RTL and testbench

Converts the four debounced button levels (left, right, drop, pop) into cursor movement and single-shot move requests for the Connect-4 game engine. Sits directly downstream of the per-button debouncers and upstream of the board/game-logic block. It edge-detects presses, auto-repeats held left/right, wraps the cursor column, and holds each drop/pop request on a valid/ready handshake until the engine accepts it.

---
 rtl/connect4_move_input.sv | 109 ++++++++++
 tb/tb_connect4_move_input.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/connect4_move_input.sv
// Button front end for the Connect-4 engine: edge detection, cursor movement
// with wrap and auto-repeat, and a single-entry valid/ready move request.
module connect4_move_input #(
  parameter int NUM_COLS     = 7,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_drop,
  input  logic       btn_pop,
  output logic [2:0] cursor_col,
  output logic       move_valid,
  output logic [2:0] move_col,
  output logic       move_pop,
  input  logic       move_ready
);

  localparam int MAXV = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW   = $clog2(MAXV + 1);
  localparam logic [CW-1:0] DLY_M1  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_M1 = CW'(REPEAT_RATE - 1);
  localparam logic [2:0]    LAST    = 3'(NUM_COLS - 1);

  typedef enum logic {IDLE, REQ} state_t;

  typedef struct packed {
    logic [2:0] col;
    logic       pop;
  } move_t;

  state_t        state, state_nx;
  move_t         mv;
  logic [3:0]    prev;      // {pop, drop, right, left}
  logic [CW-1:0] cnt;
  logic          rep_fast;  // first repeat done, now stepping at REPEAT_RATE

  logic press_l, press_r, press_d, press_p;
  logic active, launch, one_held, lr_edge, rep_hit, step, run;

  assign press_l  = btn_left  & ~prev[0];
  assign press_r  = btn_right & ~prev[1];
  assign press_d  = btn_drop  & ~prev[2];
  assign press_p  = btn_pop   & ~prev[3];

  assign active   = (state == IDLE) & enable;
  assign launch   = active & (press_d ^ press_p);
  assign one_held = btn_left ^ btn_right;
  assign lr_edge  = (btn_left ^ prev[0]) | (btn_right ^ prev[1]);
  assign rep_hit  = rep_fast ? (cnt == RATE_M1) : (cnt == DLY_M1);

  // run: a single direction is being held steadily in an idle, enabled cycle
  assign run  = active & one_held & ~launch & ~lr_edge;
  assign step = active & one_held & ~launch & (lr_edge ? (press_l | press_r) : rep_hit);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    move_valid = 1'b0;
    case (state)
      IDLE: if (launch) state_nx = REQ;
      REQ: begin
        move_valid = 1'b1;
        if (move_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev       <= {btn_pop, btn_drop, btn_right, btn_left};
      cursor_col <= 3'd0;
      mv         <= '0;
      cnt        <= '0;
      rep_fast   <= 1'b0;
    end else begin
      prev <= {btn_pop, btn_drop, btn_right, btn_left};

      if (launch) mv <= '{col: cursor_col, pop: press_p};

      if (step) begin
        if (btn_left) cursor_col <= (cursor_col == 3'd0) ? LAST : cursor_col - 3'd1;
        else          cursor_col <= (cursor_col == LAST) ? 3'd0 : cursor_col + 3'd1;
      end

      if (!run) begin
        cnt      <= '0;
        rep_fast <= 1'b0;
      end else if (rep_hit) begin
        cnt      <= '0;
        rep_fast <= 1'b1;
      end else begin
        cnt      <= cnt + 1'b1;
      end
    end
  end

  assign move_col = mv.col;
  assign move_pop = mv.pop;

endmodule

// File: tb/tb_connect4_move_input.sv
// Bench for connect4_move_input: directed scenarios plus randomized traffic
// checked against a cycle-age based reference model.
module tb_connect4_move_input;

  localparam int NC = 7;
  localparam int D  = 4;
  localparam int R  = 2;

  logic       clk = 1'b0;
  logic       rst_n, enable, btn_left, btn_right, btn_drop, btn_pop, move_ready;
  logic [2:0] cursor_col, move_col;
  logic       move_valid, move_pop;

  int checks = 0;
  int failures = 0;

  connect4_move_input #(.NUM_COLS(NC), .REPEAT_DELAY(D), .REPEAT_RATE(R)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .btn_left(btn_left), .btn_right(btn_right), .btn_drop(btn_drop), .btn_pop(btn_pop),
    .cursor_col(cursor_col), .move_valid(move_valid), .move_col(move_col),
    .move_pop(move_pop), .move_ready(move_ready)
  );

  always #5 clk = ~clk;

  // Reference model: repeat timing is expressed as the age (in cycles) since
  // the last event that restarts the hold timer.
  int t = 0, anchor = 0;
  bit m_pl, m_pr, m_pd, m_pp;
  int m_cur = 0, m_col = 0;
  bit m_pend = 0, m_pop = 0;

  task automatic model_step();
    bit pl, pr, pd, pp, act, launch, one, edg, step;
    int age;
    pl = btn_left && !m_pl;  pr = btn_right && !m_pr;
    pd = btn_drop && !m_pd;  pp = btn_pop && !m_pp;
    t++;
    if (!rst_n) begin
      m_cur = 0; m_pend = 0; m_col = 0; m_pop = 0; anchor = t;
    end else begin
      act    = !m_pend && enable;
      launch = act && (pd ^ pp);
      one    = btn_left ^ btn_right;
      edg    = (btn_left != m_pl) || (btn_right != m_pr);
      step   = 0;
      if (act && one && !launch) begin
        if (edg) step = btn_left ? pl : pr;
        else begin
          age  = t - anchor;
          step = (age == D) || (age > D && (age - D) % R == 0);
        end
      end
      if (!act || !one || edg || launch) anchor = t;
      if (step) m_cur = btn_left ? (m_cur + NC - 1) % NC : (m_cur + 1) % NC;
      if (launch) begin
        m_pend = 1; m_col = m_cur; m_pop = pp;
      end else if (m_pend && move_ready) m_pend = 0;
    end
    m_pl = btn_left; m_pr = btn_right; m_pd = btn_drop; m_pp = btn_pop;
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  task automatic idle_inputs();
    enable = 1; btn_left = 0; btn_right = 0; btn_drop = 0; btn_pop = 0; move_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0; cyc(2); rst_n = 1; cyc(1);
  endtask

  // 0 left, 1 right, 2 drop, 3 pop: one-cycle press then release
  task automatic tap(input int b);
    case (b)
      0: btn_left = 1; 1: btn_right = 1; 2: btn_drop = 1; default: btn_pop = 1;
    endcase
    cyc(1);
    btn_left = 0; btn_right = 0; btn_drop = 0; btn_pop = 0;
    cyc(1);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0; btn_drop = 1; cyc(2);
    checks++;
    if (cursor_col !== 3'd0 || move_valid !== 1'b0 || move_col !== 3'd0 || move_pop !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: cur=%0d vld=%b col=%0d pop=%b want 0/0/0/0",
               cursor_col, move_valid, move_col, move_pop);
    end
    rst_n = 1; cyc(3);
    checks++;
    if (move_valid !== 1'b0) begin
      failures++; $display("FAIL held_through_reset: vld=%b want 0", move_valid);
    end
    btn_drop = 0; cyc(1);
    btn_drop = 1; cyc(1);
    checks++;
    if (move_valid !== 1'b1 || move_pop !== 1'b0 || move_col !== 3'd0) begin
      failures++;
      $display("FAIL first_drop: vld=%b pop=%b col=%0d want 1/0/0", move_valid, move_pop, move_col);
    end
    btn_drop = 0; move_ready = 1; cyc(1);
    move_ready = 0;
    checks++;
    if (move_valid !== 1'b0) begin
      failures++; $display("FAIL first_accept: vld=%b want 0", move_valid);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    tap(0);
    checks++;
    if (cursor_col !== 3'd6) begin
      failures++; $display("FAIL wrap_left: cur=%0d want 6", cursor_col);
    end
    tap(1);
    checks++;
    if (cursor_col !== 3'd0) begin
      failures++; $display("FAIL wrap_right: cur=%0d want 0", cursor_col);
    end
    tap(1); tap(1); tap(1);
    checks++;
    if (cursor_col !== 3'd3) begin
      failures++; $display("FAIL three_right: cur=%0d want 3", cursor_col);
    end
  endtask

  task automatic test_repeat();
    do_reset();
    btn_right = 1; cyc(1);
    checks++;
    if (cursor_col !== 3'd1) begin
      failures++; $display("FAIL repeat_press: cur=%0d want 1", cursor_col);
    end
    cyc(3);
    checks++;
    if (cursor_col !== 3'd1) begin
      failures++; $display("FAIL repeat_delay_wait: cur=%0d want 1", cursor_col);
    end
    cyc(1);
    checks++;
    if (cursor_col !== 3'd2) begin
      failures++; $display("FAIL repeat_first: cur=%0d want 2", cursor_col);
    end
    cyc(5);
    checks++;
    if (cursor_col !== 3'd4) begin
      failures++; $display("FAIL repeat_hold10: cur=%0d want 4", cursor_col);
    end
    btn_right = 0; cyc(10);
    checks++;
    if (cursor_col !== 3'd4) begin
      failures++; $display("FAIL repeat_release: cur=%0d want 4", cursor_col);
    end
  endtask

  task automatic test_pending();
    do_reset();
    tap(1); tap(1); tap(1);
    btn_pop = 1; cyc(1); btn_pop = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (move_valid !== 1'b1 || move_col !== 3'd3 || move_pop !== 1'b1 || cursor_col !== 3'd3) begin
        failures++;
        $display("FAIL pending_hold[%0d]: vld=%b col=%0d pop=%b cur=%0d want 1/3/1/3",
                 i, move_valid, move_col, move_pop, cursor_col);
      end
      if (i == 1) btn_left = 1;
      if (i == 3) btn_drop = 1;
      cyc(1);
      btn_left = 0; btn_drop = 0;
    end
    move_ready = 1; cyc(1); move_ready = 0;
    checks++;
    if (move_valid !== 1'b0) begin
      failures++; $display("FAIL pending_accept: vld=%b want 0", move_valid);
    end
    cyc(4);
    checks++;
    if (move_valid !== 1'b0 || cursor_col !== 3'd3) begin
      failures++;
      $display("FAIL no_second_req: vld=%b cur=%0d want 0/3", move_valid, cursor_col);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    btn_drop = 1; btn_pop = 1; cyc(3);
    checks++;
    if (move_valid !== 1'b0) begin
      failures++; $display("FAIL drop_pop_same: vld=%b want 0", move_valid);
    end
    btn_drop = 0; btn_pop = 0;
    tap(1); tap(1);
    btn_left = 1; btn_right = 1; cyc(12);
    btn_left = 0; btn_right = 0; cyc(1);
    checks++;
    if (cursor_col !== 3'd2) begin
      failures++; $display("FAIL left_right_both: cur=%0d want 2", cursor_col);
    end
  endtask

  task automatic test_reset_mid_and_disable();
    do_reset();
    tap(1);
    btn_drop = 1; cyc(1); btn_drop = 0;
    rst_n = 0; cyc(1); rst_n = 1;
    checks++;
    if (move_valid !== 1'b0 || cursor_col !== 3'd0) begin
      failures++;
      $display("FAIL reset_mid_req: vld=%b cur=%0d want 0/0", move_valid, cursor_col);
    end
    enable = 0;
    tap(1); tap(2); tap(3);
    btn_left = 1; cyc(8); btn_left = 0; cyc(1);
    checks++;
    if (move_valid !== 1'b0 || cursor_col !== 3'd0) begin
      failures++;
      $display("FAIL disabled: vld=%b cur=%0d want 0/0", move_valid, cursor_col);
    end
    enable = 1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0)   btn_left   = ~btn_left;
      if ($urandom_range(7) == 0)   btn_right  = ~btn_right;
      if ($urandom_range(15) == 0)  btn_drop   = ~btn_drop;
      if ($urandom_range(15) == 0)  btn_pop    = ~btn_pop;
      if ($urandom_range(60) == 0)  enable     = ~enable;
      move_ready = ($urandom_range(2) == 0);
      rst_n      = ($urandom_range(400) != 0);
      cyc(1);
      checks++;
      if (cursor_col !== 3'(m_cur) || move_valid !== m_pend ||
          move_col !== 3'(m_col) || move_pop !== m_pop) begin
        failures++;
        $display("FAIL random[%0d]: cur=%0d vld=%b col=%0d pop=%b want %0d/%b/%0d/%b",
                 i, cursor_col, move_valid, move_col, move_pop, m_cur, m_pend, m_col, m_pop);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_repeat();
    test_pending();
    test_simultaneous();
    test_reset_mid_and_disable();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
